// File: rtl/arb_requester.sv
// Agent-side requester for the 4-way priority arbiter: queues burst jobs, handles the
// req/gnt handshake, issues counted beats, and flags grant timeout or grant loss.
module arb_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 16,
  parameter int TO_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             gnt,
  output logic             bus_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             job_done,
  output logic             timeout_err,
  output logic             abort_err,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [TO_W:0] TMO_C   = (TO_W+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
  state_t state, state_nxt;

  logic [LEN_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;

  logic [LEN_W-1:0] len_q, beat_q;
  logic [TO_W-1:0]  to_q;
  logic [TO_W:0]    to_inc;
  logic             to_hit;
  logic             done_nxt, tmo_nxt, abt_nxt;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push      = job_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign job_ready = !full;
  assign busy      = (state != IDLE) || !empty;
  assign beat_idx  = beat_q;

  // the timeout fires on the cycle whose gnt=0 sample would bring the count to TIMEOUT
  assign to_inc = {1'b0, to_q} + 1'b1;
  assign to_hit = (TIMEOUT != 0) && (to_inc >= TMO_C);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= job_len;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    abt_nxt   = 1'b0;
    unique case (state)
      IDLE: if (!empty) state_nxt = REQ;
      REQ: begin
        if (gnt) state_nxt = XFER;
        else if (to_hit) begin
          state_nxt = REL;
          tmo_nxt   = 1'b1;
        end
      end
      XFER: begin
        if (!gnt) begin
          state_nxt = REL;
          abt_nxt   = 1'b1;
        end else if (beat_q == len_q) begin
          state_nxt = REL;
          done_nxt  = 1'b1;
        end
      end
      REL: if (!gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      len_q       <= '0;
      beat_q      <= '0;
      to_q        <= '0;
      req         <= 1'b0;
      bus_valid   <= 1'b0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      req         <= (state_nxt == REQ) || (state_nxt == XFER);
      bus_valid   <= (state_nxt == XFER);
      job_done    <= done_nxt;
      timeout_err <= tmo_nxt;
      abort_err   <= abt_nxt;
      if (pop) len_q <= mem[rd_ptr];
      // beat counter only advances while staying in XFER, so it stops at len_q
      if (state == XFER && state_nxt == XFER) beat_q <= beat_q + 1'b1;
      else                                    beat_q <= '0;
      if (state == IDLE)                              to_q <= '0;
      else if (state == REQ && !gnt && to_q != '1)    to_q <= to_q + 1'b1;
    end
  end
endmodule
